network_if_rr_arbiter: RTL and testbench

// - Shares one downstream network_if channel between NUM_IN upstream requesters.
// - Round-robin arbitration; MAX_BURST caps consecutive beats per grant.
// - Registered output stage, so the block sits between producers and a shared

---
 rtl/network_pkg.sv | 13 +
 rtl/rr_priority_sel.sv | 36 +++
 rtl/network_if_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_network_if_rr_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/network_pkg.sv
// Shared types for the network_if round-robin arbiter.
package network_pkg;

  // Arbiter control states: free arbitration or holding a burst grant.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Generic source index carrier; narrowed to SRC_W where it is used.
  typedef logic [7:0] src_idx_t;

endpackage

// File: rtl/rr_priority_sel.sv
// Rotating priority selector: picks the first asserted request at or after
// the pointer, wrapping modulo N. Purely combinational.
module rr_priority_sel #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan requests in rotated order and keep the first hit.
  always_comb begin
    int         pos_s;
    logic [W-1:0] pos_idx_s;
    gnt       = {N{1'b0}};
    idx       = {W{1'b0}};
    any       = 1'b0;
    pos_s     = 0;
    pos_idx_s = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      pos_s     = ((int'(ptr) + i) >= N) ? (int'(ptr) + i - N) : (int'(ptr) + i);
      pos_idx_s = W'(pos_s);
      if (!any && req[pos_idx_s]) begin
        gnt[pos_idx_s] = 1'b1;
        idx            = pos_idx_s;
        any            = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/network_if_rr_arbiter.sv
// Round-robin arbiter sharing one registered network_if output channel
// between NUM_IN requesters, with per-grant burst cap and source tagging.
module network_if_rr_arbiter
  import network_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int MAX_BURST = 1,
  parameter int SRC_W     = $clog2(NUM_IN),
  parameter int VAL_W     = 32,
  parameter int ID_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN-1:0][VAL_W-1:0] in_val,
  input  logic [NUM_IN-1:0][ID_W-1:0]  in_id,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  output logic [VAL_W-1:0]             out_val,
  output logic [ID_W-1:0]              out_id,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SRC_W-1:0]             out_src,
  output logic                         busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_IN - 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  // Next index in rotation, wrapping the last input back to input 0.
  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] i);
    return (i == LAST_IDX) ? {SRC_W{1'b0}} : (i + {{(SRC_W-1){1'b0}}, 1'b1});
  endfunction

  arb_state_e         state_r, state_nxt_s;
  logic [SRC_W-1:0]   ptr_r, ptr_nxt_s;
  logic [SRC_W-1:0]   lock_idx_r, lock_nxt_s;
  logic [CNT_W-1:0]   burst_cnt_r, cnt_nxt_s, cnt_cur_s;
  logic               out_valid_r;
  logic [VAL_W-1:0]   out_val_r;
  logic [ID_W-1:0]    out_id_r;
  logic [SRC_W-1:0]   out_src_r;

  logic               load_s, accept_s, grant_vld_s;
  logic [SRC_W-1:0]   grant_idx_s;
  logic [NUM_IN-1:0]  grant_oh_s;
  logic [NUM_IN-1:0]  sel_gnt_s;
  logic [SRC_W-1:0]   sel_idx_s;
  logic               sel_any_s;

  rr_priority_sel #(.N(NUM_IN), .W(SRC_W)) u_sel (
    .req (in_valid),
    .ptr (ptr_r),
    .gnt (sel_gnt_s),
    .idx (sel_idx_s),
    .any (sel_any_s)
  );

  // Grant selection, burst accounting and pointer rotation.
  always_comb begin
    load_s      = !out_valid_r | out_ready;
    grant_idx_s = sel_idx_s;
    grant_vld_s = 1'b0;
    grant_oh_s  = {NUM_IN{1'b0}};
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    lock_nxt_s  = lock_idx_r;
    cnt_nxt_s   = burst_cnt_r;
    cnt_cur_s   = {{(CNT_W-1){1'b0}}, 1'b1};
    case (state_r)
      IDLE: begin
        grant_idx_s = sel_idx_s;
        grant_vld_s = sel_any_s;
        grant_oh_s  = sel_gnt_s;
        cnt_cur_s   = {{(CNT_W-1){1'b0}}, 1'b1};
      end
      LOCKED: begin
        grant_idx_s             = lock_idx_r;
        grant_vld_s             = in_valid[lock_idx_r];
        grant_oh_s[lock_idx_r]  = in_valid[lock_idx_r];
        cnt_cur_s               = burst_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      default: begin
        grant_vld_s = 1'b0;
      end
    endcase
    accept_s = load_s & grant_vld_s;
    if (accept_s) begin
      if (cnt_cur_s == BURST_MAX) begin
        // Burst exhausted: hand priority to the next input in rotation.
        state_nxt_s = IDLE;
        ptr_nxt_s   = wrap_inc(grant_idx_s);
        cnt_nxt_s   = {CNT_W{1'b0}};
      end else begin
        state_nxt_s = LOCKED;
        lock_nxt_s  = grant_idx_s;
        cnt_nxt_s   = cnt_cur_s;
      end
    end else if ((state_r == LOCKED) && !in_valid[lock_idx_r]) begin
      // Locked requester went quiet: give up the rest of its burst.
      state_nxt_s = IDLE;
      ptr_nxt_s   = wrap_inc(lock_idx_r);
      cnt_nxt_s   = {CNT_W{1'b0}};
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= {SRC_W{1'b0}};
      lock_idx_r  <= {SRC_W{1'b0}};
      burst_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      ptr_r       <= ptr_nxt_s;
      lock_idx_r  <= lock_nxt_s;
      burst_cnt_r <= cnt_nxt_s;
    end
  end

  // Output register: loads whenever empty or draining, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_val_r   <= {VAL_W{1'b0}};
      out_id_r    <= {ID_W{1'b0}};
      out_src_r   <= {SRC_W{1'b0}};
    end else if (load_s) begin
      out_valid_r <= accept_s;
      if (accept_s) begin
        out_val_r <= in_val[grant_idx_s];
        out_id_r  <= in_id[grant_idx_s];
        out_src_r <= grant_idx_s;
      end
    end
  end

  assign in_ready  = grant_oh_s & {NUM_IN{load_s & rst_n}};
  assign out_valid = out_valid_r;
  assign out_val   = out_val_r;
  assign out_id    = out_id_r;
  assign out_src   = out_src_r;
  assign busy      = out_valid_r | (|in_valid);

endmodule

// File: tb/tb_network_if_rr_arbiter.sv
// Self-checking bench: two arbiters (MAX_BURST=1 and 3) on shared stimulus,
// checked against directed expectations and a behavioural arbitration model.
module tb_network_if_rr_arbiter;
  localparam int N  = 4;
  localparam int VW = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [N-1:0][VW-1:0]  in_val;
  logic [N-1:0][IW-1:0]  in_id;
  logic [N-1:0]          in_valid;
  logic                  out_ready;
  logic [1:0][N-1:0]     in_ready;
  logic [1:0][VW-1:0]    out_val;
  logic [1:0][IW-1:0]    out_id;
  logic [1:0]            out_valid;
  logic [1:0][1:0]       out_src;
  logic [1:0]            busy;

  network_if_rr_arbiter #(.NUM_IN(N), .MAX_BURST(1), .VAL_W(VW), .ID_W(IW)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_id(in_id), .in_valid(in_valid),
    .in_ready(in_ready[0]), .out_val(out_val[0]), .out_id(out_id[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_src(out_src[0]), .busy(busy[0]));

  network_if_rr_arbiter #(.NUM_IN(N), .MAX_BURST(3), .VAL_W(VW), .ID_W(IW)) dut_b3 (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_id(in_id), .in_valid(in_valid),
    .in_ready(in_ready[1]), .out_val(out_val[1]), .out_id(out_id[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_src(out_src[1]), .busy(busy[1]));

  int total = 0;
  int bad   = 0;

  // Reference model: who is served next, plus the contents of the output slot.
  int          mb [2] = '{1, 3};
  int          m_ptr [2];
  int          m_cur [2];   // input currently holding a burst, -1 if none
  int          m_cnt [2];
  bit          m_valid [2];
  int          m_src [2];
  logic [VW-1:0] m_val [2];
  logic [IW-1:0] m_id [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0; m_cur[k] = -1; m_cnt[k] = 0;
      m_valid[k] = 1'b0; m_src[k] = 0; m_val[k] = '0; m_id[k] = '0;
    end
  endtask

  function automatic int m_grant(int k);
    if (!rst_n) return -1;
    if (m_cur[k] >= 0) return in_valid[m_cur[k]] ? m_cur[k] : -1;
    for (int i = 0; i < N; i++) begin
      if (in_valid[(m_ptr[k] + i) % N]) return (m_ptr[k] + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready(int k);
    logic [N-1:0] r;
    int g;
    r = '0;
    g = m_grant(k);
    if (g >= 0 && (!m_valid[k] || out_ready)) r[g] = 1'b1;
    return r;
  endfunction

  // One clock: decide from pre-edge inputs, update the model, settle #1 after.
  task automatic tick();
    int g [2];
    bit ld [2];
    logic [N-1:0][VW-1:0] v;
    logic [N-1:0][IW-1:0] d;
    logic [N-1:0] vl;
    v = in_val; d = in_id; vl = in_valid;
    for (int k = 0; k < 2; k++) begin
      g[k]  = m_grant(k);
      ld[k] = !m_valid[k] || out_ready;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (ld[k] && g[k] >= 0) begin
        m_valid[k] = 1'b1; m_src[k] = g[k]; m_val[k] = v[g[k]]; m_id[k] = d[g[k]];
        m_cnt[k]++;
        if (m_cnt[k] == mb[k]) begin
          m_ptr[k] = (g[k] + 1) % N; m_cur[k] = -1; m_cnt[k] = 0;
        end else begin
          m_cur[k] = g[k];
        end
      end else begin
        if (ld[k]) m_valid[k] = 1'b0;
        if (m_cur[k] >= 0 && !vl[m_cur[k]]) begin
          m_ptr[k] = (m_cur[k] + 1) % N; m_cur[k] = -1; m_cnt[k] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; in_valid = '1;
    for (int i = 0; i < N; i++) begin
      in_val[i] = VW'(16'h1100 + i); in_id[i] = IW'(i + 5);
    end
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (out_valid[k] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d] got=%b exp=0", k, out_valid[k]); end
      total++;
      if (in_ready[k] !== 4'b0000) begin bad++; $display("FAIL reset_ready[%0d] got=%b exp=0000", k, in_ready[k]); end
    end
    @(negedge clk); rst_n = 1'b1; #1;
    total++;
    if (in_ready[0] !== 4'b0001) begin bad++; $display("FAIL release_ready got=%b exp=0001", in_ready[0]); end
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (out_valid[k] !== 1'b1 || out_src[k] !== 2'd0 || out_val[k] !== 16'h1100 || out_id[k] !== 4'd5) begin
        bad++;
        $display("FAIL first_beat[%0d] got v=%b src=%0d val=%h id=%h exp v=1 src=0 val=1100 id=5",
                 k, out_valid[k], out_src[k], out_val[k], out_id[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [VW-1:0] exp_v;
    apply_reset();
    in_valid = '1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) in_val[i] = VW'($urandom);
      exp_v = in_val[c % N];
      tick();
      total++;
      if (out_valid[0] !== 1'b1 || out_src[0] !== 2'(c % N) || out_val[0] !== exp_v) begin
        bad++;
        $display("FAIL rr_seq c=%0d got v=%b src=%0d val=%h exp v=1 src=%0d val=%h",
                 c, out_valid[0], out_src[0], out_val[0], c % N, exp_v);
      end
    end
  endtask

  task automatic test_burst();
    int exp_s;
    apply_reset();
    in_valid = 4'b0110;
    for (int c = 0; c < 10; c++) begin
      exp_s = ((c / 3) % 2 == 0) ? 1 : 2;
      tick();
      total++;
      if (out_valid[1] !== 1'b1 || out_src[1] !== 2'(exp_s)) begin
        bad++;
        $display("FAIL burst_seq c=%0d got v=%b src=%0d exp v=1 src=%0d", c, out_valid[1], out_src[1], exp_s);
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    in_valid = '1;
    for (int i = 0; i < N; i++) begin
      in_val[i] = VW'(16'hA000 + i); in_id[i] = IW'(i);
    end
    tick(); tick();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (in_ready[0] !== 4'b0000) begin bad++; $display("FAIL stall_ready c=%0d got=%b exp=0000", c, in_ready[0]); end
      tick();
      total++;
      if (out_valid[0] !== 1'b1 || out_src[0] !== 2'd1 || out_val[0] !== 16'hA001 || out_id[0] !== 4'd1) begin
        bad++;
        $display("FAIL stall_hold c=%0d got v=%b src=%0d val=%h id=%h exp v=1 src=1 val=a001 id=1",
                 c, out_valid[0], out_src[0], out_val[0], out_id[0]);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (out_valid[0] !== 1'b1 || out_src[0] !== 2'(c + 2)) begin
        bad++;
        $display("FAIL stall_resume c=%0d got v=%b src=%0d exp v=1 src=%0d", c, out_valid[0], out_src[0], c + 2);
      end
    end
  endtask

  task automatic test_single();
    apply_reset();
    in_valid = 4'b1000;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (out_valid[k] !== 1'b1 || out_src[k] !== 2'd3) begin
          bad++;
          $display("FAIL single[%0d] c=%0d got v=%b src=%0d exp v=1 src=3", k, c, out_valid[k], out_src[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    in_valid = '1;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (out_valid[k] !== 1'b0) begin bad++; $display("FAIL midrst_valid[%0d] got=%b exp=0", k, out_valid[k]); end
    end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (out_valid[k] !== 1'b1 || out_src[k] !== 2'd0) begin
        bad++;
        $display("FAIL midrst_ptr[%0d] got v=%b src=%0d exp v=1 src=0", k, out_valid[k], out_src[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        in_val[i] = VW'($urandom); in_id[i] = IW'($urandom);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        er = m_ready(k);
        total++;
        if (in_ready[k] !== er) begin bad++; $display("FAIL rnd_ready[%0d] c=%0d got=%b exp=%b", k, c, in_ready[k], er); end
        total++;
        if (busy[k] !== (m_valid[k] | (|in_valid))) begin
          bad++; $display("FAIL rnd_busy[%0d] c=%0d got=%b exp=%b", k, c, busy[k], m_valid[k] | (|in_valid));
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (out_valid[k] !== m_valid[k] ||
            (m_valid[k] && (out_src[k] !== 2'(m_src[k]) || out_val[k] !== m_val[k] || out_id[k] !== m_id[k]))) begin
          bad++;
          $display("FAIL rnd_out[%0d] c=%0d got v=%b src=%0d val=%h id=%h exp v=%b src=%0d val=%h id=%h",
                   k, c, out_valid[k], out_src[k], out_val[k], out_id[k], m_valid[k], m_src[k], m_val[k], m_id[k]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b1; in_val = '0; in_id = '0;
    test_reset();
    test_round_robin();
    test_burst();
    test_stall();
    test_single();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
